// File: rtl/fpu_issue_ctrl.sv
// Credit-based issue controller for a single-cycle-latency FPU with an in-order response FIFO.
// Optional sticky exception-flag accumulator enabled by defining FPU_ISSUE_FFLAGS_EN.
module fpu_issue_ctrl #(
  parameter int RESP_DEPTH = 4,
  parameter int TAG_WIDTH  = 4,
  parameter int OP_WIDTH   = 7
) (
  input  logic                 Clk_CI,
  input  logic                 Rst_RI,
  input  logic                 ReqValid_SI,
  output logic                 ReqReady_SO,
  input  logic [31:0]          ReqOpA_DI,
  input  logic [31:0]          ReqOpB_DI,
  input  logic [OP_WIDTH-1:0]  ReqOp_SI,
  input  logic [2:0]           ReqRM_SI,
  input  logic [TAG_WIDTH-1:0] ReqTag_DI,
  output logic                 RespValid_SO,
  input  logic                 RespReady_SI,
  output logic [31:0]          RespResult_DO,
  output logic [TAG_WIDTH-1:0] RespTag_DO,
  output logic [5:0]           RespFlags_DO,
  output logic [31:0]          FpuOperandA_DO,
  output logic [31:0]          FpuOperandB_DO,
  output logic [OP_WIDTH-1:0]  FpuOP_SO,
  output logic [2:0]           FpuRM_SO,
  output logic                 FpuEnable_SO,
  input  logic [31:0]          FpuResult_DI,
  input  logic                 FpuValid_DI,
  input  logic                 FpuOF_SI,
  input  logic                 FpuUF_SI,
  input  logic                 FpuZero_SI,
  input  logic                 FpuIX_SI,
  input  logic                 FpuIV_SI,
  input  logic                 FpuInf_SI,
  input  logic                 Flush_SI,
  input  logic                 FFlagsClr_SI,
  output logic [4:0]           FFlags_DO,
  output logic                 Busy_SO,
  output logic                 ProtErr_SO
);

  localparam int PTR_W   = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CNT_W   = $clog2(RESP_DEPTH + 1);
  localparam int ENTRY_W = 32 + TAG_WIDTH + 6;

  logic [ENTRY_W-1:0]   mem_q [RESP_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 inflight_q, inflight_d;
  logic [TAG_WIDTH-1:0] tag_q, tag_d;
  logic                 prot_err_q, prot_err_d;
  logic [CNT_W:0]       credits_used;
  logic                 issue, push, pop, lost;
  logic [5:0]           fpu_flags;
  logic [ENTRY_W-1:0]   head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Valid/ready: a transfer happens in a cycle where valid and ready are both high;
  // ready never depends combinationally on the consumer's ready, only on held credits.
  assign credits_used = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
  assign ReqReady_SO  = ~Flush_SI & (credits_used < (CNT_W+1)'(RESP_DEPTH));
  assign issue        = ReqValid_SI & ReqReady_SO & ~Rst_RI;

  assign FpuEnable_SO   = issue;
  assign FpuOperandA_DO = issue ? ReqOpA_DI : '0;
  assign FpuOperandB_DO = issue ? ReqOpB_DI : '0;
  assign FpuOP_SO       = issue ? ReqOp_SI  : '0;
  assign FpuRM_SO       = issue ? ReqRM_SI  : '0;

  assign fpu_flags    = {FpuIV_SI, FpuInf_SI, FpuOF_SI, FpuUF_SI, FpuZero_SI, FpuIX_SI};
  assign push         = ~Flush_SI & inflight_q & FpuValid_DI;
  assign lost         = ~Flush_SI & inflight_q & ~FpuValid_DI;
  assign RespValid_SO = (count_q != '0);
  assign pop          = ~Flush_SI & RespValid_SO & RespReady_SI;

  always_comb begin
    wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d   = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d    = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    inflight_d = issue;
    tag_d      = issue ? ReqTag_DI : tag_q;
    prot_err_d = prot_err_q | lost;
    if (Flush_SI) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
      tag_q      <= '0;
      prot_err_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      tag_q      <= tag_d;
      prot_err_q <= prot_err_d;
    end
  end

  // Storage needs no reset: the head is only exposed while the count is non-zero.
  always_ff @(posedge Clk_CI) begin
    if (push) mem_q[wr_ptr_q] <= {FpuResult_DI, tag_q, fpu_flags};
  end

  assign head = mem_q[rd_ptr_q];
  assign {RespResult_DO, RespTag_DO, RespFlags_DO} = RespValid_SO ? head : '0;
  assign Busy_SO    = inflight_q | RespValid_SO;
  assign ProtErr_SO = prot_err_q;

`ifdef FPU_ISSUE_FFLAGS_EN
  logic [4:0] fflags_q, fflags_d;

  // A clear coinciding with a capture keeps only the newly captured flags.
  always_comb begin
    fflags_d = fflags_q;
    if (!Flush_SI) begin
      if (push)
        fflags_d = (FFlagsClr_SI ? 5'b0 : fflags_q) | {FpuIV_SI, 1'b0, FpuOF_SI, FpuUF_SI, FpuIX_SI};
      else if (FFlagsClr_SI)
        fflags_d = 5'b0;
    end
  end

  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) fflags_q <= 5'b0;
    else        fflags_q <= fflags_d;
  end

  assign FFlags_DO = fflags_q;
`else
  logic unused_fflags_clr;
  assign unused_fflags_clr = FFlagsClr_SI;
  assign FFlags_DO = 5'b0;
`endif

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Bench for fpu_issue_ctrl: a behavioural FPU stand-in plus a queue-based response/credit model.
// Honours FPU_ISSUE_FFLAGS_EN the same way as the design.
module tb_fpu_issue_ctrl;

  localparam int DEPTH = 4;
  localparam int TW    = 4;
  localparam int OW    = 7;
  localparam int EW    = 32 + TW + 6;
  localparam logic [OW-1:0] OP_ADD = 7'd0;
  localparam logic [OW-1:0] OP_MUL = 7'd2;

  logic          Clk_CI, Rst_RI;
  logic          ReqValid_SI, ReqReady_SO;
  logic [31:0]   ReqOpA_DI, ReqOpB_DI;
  logic [OW-1:0] ReqOp_SI;
  logic [2:0]    ReqRM_SI;
  logic [TW-1:0] ReqTag_DI;
  logic          RespValid_SO, RespReady_SI;
  logic [31:0]   RespResult_DO;
  logic [TW-1:0] RespTag_DO;
  logic [5:0]    RespFlags_DO;
  logic [31:0]   FpuOperandA_DO, FpuOperandB_DO;
  logic [OW-1:0] FpuOP_SO;
  logic [2:0]    FpuRM_SO;
  logic          FpuEnable_SO;
  logic [31:0]   FpuResult_DI;
  logic          FpuValid_DI;
  logic          FpuOF_SI, FpuUF_SI, FpuZero_SI, FpuIX_SI, FpuIV_SI, FpuInf_SI;
  logic          Flush_SI, FFlagsClr_SI;
  logic [4:0]    FFlags_DO;
  logic          Busy_SO, ProtErr_SO;

  fpu_issue_ctrl #(.RESP_DEPTH(DEPTH), .TAG_WIDTH(TW), .OP_WIDTH(OW)) dut (
    .Clk_CI(Clk_CI), .Rst_RI(Rst_RI),
    .ReqValid_SI(ReqValid_SI), .ReqReady_SO(ReqReady_SO),
    .ReqOpA_DI(ReqOpA_DI), .ReqOpB_DI(ReqOpB_DI), .ReqOp_SI(ReqOp_SI), .ReqRM_SI(ReqRM_SI),
    .ReqTag_DI(ReqTag_DI),
    .RespValid_SO(RespValid_SO), .RespReady_SI(RespReady_SI),
    .RespResult_DO(RespResult_DO), .RespTag_DO(RespTag_DO), .RespFlags_DO(RespFlags_DO),
    .FpuOperandA_DO(FpuOperandA_DO), .FpuOperandB_DO(FpuOperandB_DO), .FpuOP_SO(FpuOP_SO),
    .FpuRM_SO(FpuRM_SO), .FpuEnable_SO(FpuEnable_SO),
    .FpuResult_DI(FpuResult_DI), .FpuValid_DI(FpuValid_DI),
    .FpuOF_SI(FpuOF_SI), .FpuUF_SI(FpuUF_SI), .FpuZero_SI(FpuZero_SI), .FpuIX_SI(FpuIX_SI),
    .FpuIV_SI(FpuIV_SI), .FpuInf_SI(FpuInf_SI),
    .Flush_SI(Flush_SI), .FFlagsClr_SI(FFlagsClr_SI), .FFlags_DO(FFlags_DO),
    .Busy_SO(Busy_SO), .ProtErr_SO(ProtErr_SO)
  );

  // ---------------- clock ----------------
  initial begin
    Clk_CI = 1'b0;
    forever #5 Clk_CI = ~Clk_CI;
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] m_pend;
  logic          m_inflight = 1'b0;
  logic          m_perr = 1'b0;
  logic [4:0]    m_ff = 5'd0;
  logic          drop_next = 1'b0;

  logic          s_ready, s_enable, s_resp_valid, s_busy, s_perr, s_popped;
  logic [TW-1:0] s_resp_tag;
  logic [31:0]   s_resp_result, s_fpu_a, s_fpu_b;
  logic [5:0]    s_resp_flags;
  logic [4:0]    s_fflags;
  logic [OW-1:0] s_fpu_op;

  // Behavioural FPU: a few exact IEEE cases used by directed tests, otherwise a bit mix.
  function automatic logic [37:0] fpu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [OW-1:0] op);
    if (op == OP_ADD && a == 32'h3F800000 && b == 32'h40000000) return {32'h40400000, 6'b0};
    if (op == OP_ADD && a == 32'h3F800000 && b == 32'h3F800000) return {32'h40000000, 6'b0};
    if (op == OP_MUL && a == 32'h7F7FFFFF && b == 32'h7F7FFFFF) return {32'h7F800000, 6'b011001};
    return {a ^ {b[15:0], b[31:16]} ^ {25'd0, op}, a[5:0] & b[11:6]};
  endfunction

  function automatic logic [4:0] to_fflags(input logic [5:0] f);
    return {f[5], 1'b0, f[3], f[2], f[0]};
  endfunction

  task automatic set_req(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [OW-1:0] op, input logic [TW-1:0] tag);
    ReqValid_SI = v;
    ReqOpA_DI   = a;
    ReqOpB_DI   = b;
    ReqOp_SI    = op;
    ReqRM_SI    = 3'($urandom_range(0, 4));
    ReqTag_DI   = tag;
  endtask

  task automatic set_req_rand(input logic [TW-1:0] tag);
    set_req(1'b1, $urandom, $urandom, OW'($urandom_range(0, 127)), tag);
  endtask

  // One clock cycle: sample just before the rising edge, score against the model,
  // advance the model, then play the FPU's response for the next cycle.
  task automatic tick();
    logic          exp_ready, exp_issue, exp_valid, capture;
    logic [37:0]   fr;
    logic [77:0]   exp_fpu;
    #4;
    s_ready = ReqReady_SO;  s_enable = FpuEnable_SO;  s_resp_valid = RespValid_SO;
    s_resp_tag = RespTag_DO; s_resp_result = RespResult_DO; s_resp_flags = RespFlags_DO;
    s_busy = Busy_SO; s_perr = ProtErr_SO; s_fflags = FFlags_DO;
    s_fpu_a = FpuOperandA_DO; s_fpu_b = FpuOperandB_DO; s_fpu_op = FpuOP_SO;

    exp_ready = !Flush_SI && ((exp_q.size() + int'(m_inflight)) < DEPTH);
    exp_issue = ReqValid_SI && exp_ready;
    exp_valid = exp_q.size() != 0;
    exp_fpu   = exp_issue ? {ReqOpA_DI, ReqOpB_DI, ReqOp_SI, ReqRM_SI} : 78'd0;

    checks++; if (ReqReady_SO !== exp_ready)
      begin errors++; $display("FAIL req_ready t=%0t got %b exp %b", $time, ReqReady_SO, exp_ready); end
    checks++; if (FpuEnable_SO !== exp_issue)
      begin errors++; $display("FAIL fpu_enable t=%0t got %b exp %b", $time, FpuEnable_SO, exp_issue); end
    checks++; if ({FpuOperandA_DO, FpuOperandB_DO, FpuOP_SO, FpuRM_SO} !== exp_fpu)
      begin errors++; $display("FAIL fpu_launch t=%0t got %h exp %h", $time,
            {FpuOperandA_DO, FpuOperandB_DO, FpuOP_SO, FpuRM_SO}, exp_fpu); end
    checks++; if (RespValid_SO !== exp_valid)
      begin errors++; $display("FAIL resp_valid t=%0t got %b exp %b", $time, RespValid_SO, exp_valid); end
    if (exp_valid) begin
      checks++; if ({RespResult_DO, RespTag_DO, RespFlags_DO} !== exp_q[0])
        begin errors++; $display("FAIL resp_payload t=%0t got %h exp %h", $time,
              {RespResult_DO, RespTag_DO, RespFlags_DO}, exp_q[0]); end
    end
    checks++; if (Busy_SO !== (m_inflight || exp_valid))
      begin errors++; $display("FAIL busy t=%0t got %b exp %b", $time, Busy_SO, m_inflight || exp_valid); end
    checks++; if (ProtErr_SO !== m_perr)
      begin errors++; $display("FAIL prot_err t=%0t got %b exp %b", $time, ProtErr_SO, m_perr); end
    checks++; if (FFlags_DO !== m_ff)
      begin errors++; $display("FAIL fflags t=%0t got %b exp %b", $time, FFlags_DO, m_ff); end

    s_popped = 1'b0;
    if (Flush_SI) begin
      exp_q.delete();
      m_inflight = 1'b0;
    end else begin
      if (exp_valid && RespReady_SI) begin
        void'(exp_q.pop_front());
        s_popped = 1'b1;
      end
      capture = m_inflight && FpuValid_DI;
      if (capture) exp_q.push_back(m_pend);
      if (m_inflight && !FpuValid_DI) m_perr = 1'b1;
`ifdef FPU_ISSUE_FFLAGS_EN
      if (capture) m_ff = (FFlagsClr_SI ? 5'd0 : m_ff) | to_fflags(m_pend[5:0]);
      else if (FFlagsClr_SI) m_ff = 5'd0;
`endif
      m_inflight = exp_issue;
      if (exp_issue) begin
        fr = fpu_model(ReqOpA_DI, ReqOpB_DI, ReqOp_SI);
        m_pend = {fr[37:6], ReqTag_DI, fr[5:0]};
      end
    end

    @(negedge Clk_CI);
    if (s_enable) begin
      fr = fpu_model(s_fpu_a, s_fpu_b, s_fpu_op);
      FpuValid_DI = !drop_next;
      drop_next = 1'b0;
    end else begin
      fr = {$urandom, 6'($urandom)};
      FpuValid_DI = ($urandom_range(0, 3) == 0);
    end
    FpuResult_DI = fr[37:6];
    {FpuIV_SI, FpuInf_SI, FpuOF_SI, FpuUF_SI, FpuZero_SI, FpuIX_SI} = fr[5:0];
  endtask

  task automatic drain();
    ReqValid_SI = 1'b0; RespReady_SI = 1'b1; Flush_SI = 1'b0; FFlagsClr_SI = 1'b0;
    for (int i = 0; i < 8; i++) tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    checks++; if (ReqReady_SO !== 1'b1)
      begin errors++; $display("FAIL reset_ready got %b exp 1", ReqReady_SO); end
    checks++; if ({RespValid_SO, RespResult_DO, RespTag_DO, RespFlags_DO, FpuEnable_SO,
                   FpuOperandA_DO, FpuOperandB_DO, FpuOP_SO, FpuRM_SO, FFlags_DO, Busy_SO, ProtErr_SO} !== '0)
      begin errors++; $display("FAIL reset_outputs got nonzero exp all zero"); end
  endtask

  task automatic test_add();
    RespReady_SI = 1'b1;
    set_req(1'b1, 32'h3F800000, 32'h40000000, OP_ADD, 4'd3);
    tick();
    checks++; if (s_enable !== 1'b1) begin errors++; $display("FAIL add_enable got %b exp 1", s_enable); end
    ReqValid_SI = 1'b0;
    tick();
    checks++; if (s_resp_valid !== 1'b0) begin errors++; $display("FAIL add_early got %b exp 0", s_resp_valid); end
    tick();
    checks++; if ({s_resp_valid, s_resp_result, s_resp_tag, s_resp_flags} !== {1'b1, 32'h40400000, 4'd3, 6'd0})
      begin errors++; $display("FAIL add_resp got v=%b r=%h t=%0d f=%b exp v=1 r=40400000 t=3 f=0",
            s_resp_valid, s_resp_result, s_resp_tag, s_resp_flags); end
    drain();
  endtask

  task automatic test_back_to_back();
    int resp_t[$];
    logic [TW-1:0] tags[$];
    logic busy_at[12];
    RespReady_SI = 1'b1;
    for (int t = 0; t < 12; t++) begin
      if (t < 8) set_req_rand(TW'(t)); else ReqValid_SI = 1'b0;
      tick();
      busy_at[t] = s_busy;
      if (t < 8) begin
        checks++; if (s_enable !== 1'b1) begin errors++; $display("FAIL b2b_issue t=%0d got 0 exp 1", t); end
      end
      if (s_resp_valid) begin resp_t.push_back(t); tags.push_back(s_resp_tag); end
    end
    checks++; if (resp_t.size() != 8 || resp_t[0] != 2 || resp_t[7] != 9)
      begin errors++; $display("FAIL b2b_timing got n=%0d exp 8 responses at cycles 2..9", resp_t.size()); end
    for (int i = 0; i < tags.size() && i < 8; i++) begin
      checks++; if (tags[i] !== TW'(i)) begin errors++; $display("FAIL b2b_order i=%0d got %0d exp %0d", i, tags[i], i); end
    end
    checks++; if ({busy_at[9], busy_at[10]} !== 2'b10)
      begin errors++; $display("FAIL b2b_busy got %b%b exp 10", busy_at[9], busy_at[10]); end
    drain();
  endtask

  task automatic test_backpressure();
    int accepts = 0;
    logic [TW-1:0] tags[$];
    RespReady_SI = 1'b0;
    for (int i = 0; i < 8; i++) begin
      set_req_rand(TW'(accepts)); tick();
      if (s_enable) accepts++;
    end
    checks++; if (accepts != 4 || s_ready !== 1'b0)
      begin errors++; $display("FAIL bp_fill got %0d accepts ready=%b exp 4 ready=0", accepts, s_ready); end
    RespReady_SI = 1'b1; set_req_rand(TW'(accepts)); tick();
    if (s_popped) tags.push_back(s_resp_tag);
    RespReady_SI = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_req_rand(TW'(accepts)); tick();
      if (s_enable) accepts++;
    end
    checks++; if (accepts != 5) begin errors++; $display("FAIL bp_one_more got %0d exp 5", accepts); end
    ReqValid_SI = 1'b0; RespReady_SI = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (s_popped) tags.push_back(s_resp_tag);
    end
    checks++; if (tags.size() != 5) begin errors++; $display("FAIL bp_count got %0d exp 5", tags.size()); end
    for (int i = 0; i < tags.size(); i++) begin
      checks++; if (tags[i] !== TW'(i)) begin errors++; $display("FAIL bp_order i=%0d got %0d exp %0d", i, tags[i], i); end
    end
  endtask

  task automatic test_flags();
    logic exp_of;
`ifdef FPU_ISSUE_FFLAGS_EN
    exp_of = 1'b1;
`else
    exp_of = 1'b0;
`endif
    RespReady_SI = 1'b1;
    set_req(1'b1, 32'h7F7FFFFF, 32'h7F7FFFFF, OP_MUL, 4'd1); tick();
    ReqValid_SI = 1'b0; tick(); tick();
    checks++; if (s_resp_flags[3] !== 1'b1 || s_fflags[2] !== exp_of)
      begin errors++; $display("FAIL flags_mul got resp_of=%b ff_of=%b exp 1 %b", s_resp_flags[3], s_fflags[2], exp_of); end
    set_req(1'b1, 32'h3F800000, 32'h3F800000, OP_ADD, 4'd2); tick();
    ReqValid_SI = 1'b0; tick(); tick();
    checks++; if (s_resp_result !== 32'h40000000 || s_fflags[2] !== exp_of)
      begin errors++; $display("FAIL flags_add got r=%h ff_of=%b exp 40000000 %b", s_resp_result, s_fflags[2], exp_of); end
    FFlagsClr_SI = 1'b1; tick();
    FFlagsClr_SI = 1'b0; tick();
    checks++; if (s_fflags !== 5'd0) begin errors++; $display("FAIL flags_clr got %b exp 0", s_fflags); end
    drain();
  endtask

  task automatic test_flush();
    RespReady_SI = 1'b0;
    for (int i = 0; i < 3; i++) begin set_req_rand(TW'(i)); tick(); end
    Flush_SI = 1'b1; set_req_rand(4'd7); tick();
    checks++; if ({s_resp_valid, s_busy, s_ready, s_enable} !== 4'b1100)
      begin errors++; $display("FAIL flush_cycle got %b exp 1100", {s_resp_valid, s_busy, s_ready, s_enable}); end
    Flush_SI = 1'b0; RespReady_SI = 1'b1; set_req_rand(4'd9); tick();
    checks++; if ({s_resp_valid, s_ready, s_enable} !== 3'b011)
      begin errors++; $display("FAIL flush_after got %b exp 011", {s_resp_valid, s_ready, s_enable}); end
    ReqValid_SI = 1'b0; tick();
    checks++; if (s_resp_valid !== 1'b0) begin errors++; $display("FAIL flush_discard got %b exp 0", s_resp_valid); end
    tick();
    checks++; if (s_resp_valid !== 1'b1 || s_resp_tag !== 4'd9)
      begin errors++; $display("FAIL flush_new got v=%b tag=%0d exp 1 9", s_resp_valid, s_resp_tag); end
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      set_req_rand(TW'($urandom));
      ReqValid_SI  = ($urandom_range(0, 3) != 0);
      RespReady_SI = ($urandom_range(0, 2) != 0);
      Flush_SI     = ($urandom_range(0, 39) == 0);
      FFlagsClr_SI = ($urandom_range(0, 19) == 0);
      drop_next    = ($urandom_range(0, 29) == 0);
      tick();
    end
    drop_next = 1'b0;
    drain();
  endtask

  task automatic test_error_reset();
    RespReady_SI = 1'b1; drop_next = 1'b1;
    set_req_rand(4'd5); tick();
    ReqValid_SI = 1'b0; tick(); tick();
    checks++; if ({s_perr, s_ready, s_busy, s_resp_valid} !== 4'b1100)
      begin errors++; $display("FAIL lost_result got %b exp 1100", {s_perr, s_ready, s_busy, s_resp_valid}); end
    RespReady_SI = 1'b0;
    for (int i = 0; i < 3; i++) begin set_req_rand(TW'(i)); tick(); end
    #2 Rst_RI = 1'b1;
    #1;
    checks++; if (ReqReady_SO !== 1'b1) begin errors++; $display("FAIL async_rst_ready got %b exp 1", ReqReady_SO); end
    checks++; if ({RespValid_SO, RespResult_DO, RespTag_DO, RespFlags_DO, FpuEnable_SO,
                   FpuOperandA_DO, FpuOperandB_DO, FpuOP_SO, FpuRM_SO, FFlags_DO, Busy_SO, ProtErr_SO} !== '0)
      begin errors++; $display("FAIL async_rst_outputs got v=%b busy=%b perr=%b en=%b exp all zero",
            RespValid_SO, Busy_SO, ProtErr_SO, FpuEnable_SO); end
    @(negedge Clk_CI);
    Rst_RI = 1'b0; ReqValid_SI = 1'b0; FpuValid_DI = 1'b0;
    exp_q.delete(); m_inflight = 1'b0; m_perr = 1'b0; m_ff = 5'd0;
    test_add();
  endtask

  // ---------------- main ----------------
  initial begin
    Rst_RI = 1'b1;
    set_req(1'b0, 32'd0, 32'd0, '0, '0);
    RespReady_SI = 1'b0; Flush_SI = 1'b0; FFlagsClr_SI = 1'b0;
    FpuResult_DI = 32'd0; FpuValid_DI = 1'b0;
    {FpuIV_SI, FpuInf_SI, FpuOF_SI, FpuUF_SI, FpuZero_SI, FpuIX_SI} = 6'd0;
    #2;
    test_reset();
    @(negedge Clk_CI);
    @(negedge Clk_CI);
    Rst_RI = 1'b0;
    test_add();
    test_back_to_back();
    test_backpressure();
    test_flags();
    test_flush();
    test_random();
    test_error_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
